// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment readback path: active-low segment
// patterns (bit0=a .. bit6=g) and the collect/hold state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_pat_decode.sv
// Combinational decode of one active-low segment pattern into a hex nibble,
// a minus-sign indication and an invalid-pattern flag.
module seg7_pat_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] nibble,
    output logic       is_minus,
    output logic       invalid
);

    // Pattern lookup; anything unrecognised decodes as 0 and flags invalid.
    always_comb begin
        nibble   = 4'h0;
        is_minus = 1'b0;
        invalid  = 1'b0;
        case (pat)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_MINUS: is_minus = 1'b1;
            SEG_BLANK: nibble = 4'h0;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_readback.sv
// Samples a multiplexed 7-segment bus, filters each digit for stability,
// decodes it and presents the assembled word on a valid/ready handshake.
// Optional decimal-point capture is enabled by defining SEG7_DP_EN.
module seg7_readback
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int DIG_W  = 2,
    parameter int STABLE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seg_valid,
    input  logic [DIG_W-1:0]  seg_dig,
    input  logic [6:0]        seg_in,
`ifdef SEG7_DP_EN
    input  logic              seg_dp,
    output logic [NDIG-1:0]   dp_out,
`endif
    output logic [4*NDIG-1:0] word_out,
    output logic              neg_out,
    output logic              err_out,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CW = 4;
`ifdef SEG7_DP_EN
    localparam int PW = 8;
`else
    localparam int PW = 7;
`endif

    state_t            state_r, state_nxt_s;
    logic [PW-1:0]     last_r    [NDIG];
    logic [CW-1:0]     cnt_r     [NDIG];
    logic [CW-1:0]     cnt_nxt_s [NDIG];
    logic [3:0]        nib_r     [NDIG];
    logic [NDIG-1:0]   committed_r, err_r, hit_s, commit_s;
    logic              neg_r, load_s, clear_s;
    logic [PW-1:0]     sample_s;
    logic [31:0]       dig_idx_s;
    logic [4*NDIG-1:0] word_s;
    logic [3:0]        dec_nib_s;
    logic              dec_minus_s, dec_inv_s;
`ifdef SEG7_DP_EN
    logic [NDIG-1:0]   dp_r;
    assign sample_s = {seg_dp, seg_in};
`else
    assign sample_s = seg_in;
`endif
    assign dig_idx_s = 32'(seg_dig);

    seg7_pat_decode u_dec (
        .pat      (seg_in),
        .nibble   (dec_nib_s),
        .is_minus (dec_minus_s),
        .invalid  (dec_inv_s)
    );

    // Per-digit stability count after this sample and the resulting commit decision.
    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            hit_s[i] = seg_valid && (dig_idx_s == 32'(i));
            if (sample_s == last_r[i]) begin
                if (cnt_r[i] >= CW'(STABLE)) begin
                    cnt_nxt_s[i] = CW'(STABLE);
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + 4'd1;
                end
            end else begin
                cnt_nxt_s[i] = 4'd1;
            end
            commit_s[i] = hit_s[i] && (cnt_nxt_s[i] >= CW'(STABLE)) &&
                          !committed_r[i] && (state_r == COLLECT);
        end
    end

    // Next-state logic: load the word once every digit is committed, release on handshake.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            COLLECT: begin
                if (&committed_r) begin
                    state_nxt_s = HOLD;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_nxt_s = COLLECT;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = COLLECT;
        endcase
    end

    // Word assembly, most significant digit in the top nibble.
    always_comb begin
        word_s = {(4*NDIG){1'b0}};
        for (int i = 0; i < NDIG; i++) begin
            word_s[4*i +: 4] = nib_r[i];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Per-digit tracking and commit; minus on any digit but the top one is an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NDIG; i++) begin
                last_r[i] <= {PW{1'b1}};
                cnt_r[i]  <= 4'd0;
                nib_r[i]  <= 4'h0;
            end
            committed_r <= {NDIG{1'b0}};
            err_r       <= {NDIG{1'b0}};
            neg_r       <= 1'b0;
`ifdef SEG7_DP_EN
            dp_r        <= {NDIG{1'b0}};
`endif
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (hit_s[i]) begin
                    last_r[i] <= sample_s;
                    cnt_r[i]  <= cnt_nxt_s[i];
                end
                if (commit_s[i]) begin
                    committed_r[i] <= 1'b1;
                    nib_r[i]       <= dec_nib_s;
                    err_r[i]       <= dec_inv_s | (dec_minus_s && (i != NDIG - 1));
`ifdef SEG7_DP_EN
                    dp_r[i]        <= seg_dp;
`endif
                end else if (clear_s) begin
                    committed_r[i] <= 1'b0;
                    err_r[i]       <= 1'b0;
                end
            end
            if (commit_s[NDIG-1]) begin
                neg_r <= dec_minus_s;
            end else if (clear_s) begin
                neg_r <= 1'b0;
            end
        end
    end

    // Registered outputs, frozen while the word is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_out  <= {(4*NDIG){1'b0}};
            neg_out   <= 1'b0;
            err_out   <= 1'b0;
            out_valid <= 1'b0;
`ifdef SEG7_DP_EN
            dp_out    <= {NDIG{1'b0}};
`endif
        end else if (load_s) begin
            word_out  <= word_s;
            neg_out   <= neg_r;
            err_out   <= |err_r;
            out_valid <= 1'b1;
`ifdef SEG7_DP_EN
            dp_out    <= dp_r;
`endif
        end else if (clear_s) begin
            out_valid <= 1'b0;
        end
    end

endmodule
